// File: rtl/fft_stage_sched_if.sv
// Sample-RAM / twiddle-ROM / butterfly bus of the radix-2 FFT stage sequencer.
// master = sequencer side, slave = memory and butterfly side.
interface fft_stage_sched_if #(
    parameter int unsigned LOG2N   = 4,
    parameter int unsigned WORD_SZ = 32
);
    logic                 i_start;
    logic                 o_busy;
    logic                 o_done;
    logic [LOG2N-1:0]     o_stage;

    logic                 o_rd_en;
    logic [LOG2N-1:0]     o_rd_addr_a;
    logic [LOG2N-1:0]     o_rd_addr_b;
    logic [LOG2N-2:0]     o_tw_addr;
    logic [WORD_SZ-1:0]   i_rd_data_a;
    logic [WORD_SZ-1:0]   i_rd_data_b;
    logic [WORD_SZ-1:0]   i_tw_data;

    logic [WORD_SZ-1:0]   o_bf_A;
    logic [WORD_SZ-1:0]   o_bf_B;
    logic [WORD_SZ-1:0]   o_bf_twiddle;
    logic [WORD_SZ-1:0]   i_bf_A;
    logic [WORD_SZ-1:0]   i_bf_B;

    logic                 o_wr_en;
    logic [LOG2N-1:0]     o_wr_addr_a;
    logic [LOG2N-1:0]     o_wr_addr_b;
    logic [WORD_SZ-1:0]   o_wr_data_a;
    logic [WORD_SZ-1:0]   o_wr_data_b;

    modport master (
        input  i_start, i_rd_data_a, i_rd_data_b, i_tw_data, i_bf_A, i_bf_B,
        output o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
               o_bf_A, o_bf_B, o_bf_twiddle,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, o_wr_data_a, o_wr_data_b
    );

    modport slave (
        output i_start, i_rd_data_a, i_rd_data_b, i_tw_data, i_bf_A, i_bf_B,
        input  o_busy, o_done, o_stage, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
               o_bf_A, o_bf_B, o_bf_twiddle,
               o_wr_en, o_wr_addr_a, o_wr_addr_b, o_wr_data_a, o_wr_data_b
    );
endinterface

// File: rtl/fft_stage_sched.sv
// In-place radix-2 DIT FFT stage sequencer: one butterfly per cycle, read -> compute/write-back.
// Optional FFT_STAGE_SCHED_SCALE_EN halves each real/imag part on write-back (1/N overall).
module fft_stage_sched #(
    parameter int unsigned LOG2N    = 4,
    parameter int unsigned WORD_SZ  = 32,
    parameter int unsigned WORD_MID = 16
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    fft_stage_sched_if.master  bus
);
    localparam int unsigned N      = 1 << LOG2N;
    localparam int unsigned HALF_N = N / 2;
    localparam int unsigned BF_W   = LOG2N - 1;
    localparam int unsigned TW_W   = LOG2N - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LOG2N-1:0]   stage;
    logic [LOG2N-1:0]   stage_nxt;
    logic [BF_W-1:0]    bfly;
    logic [BF_W-1:0]    bfly_nxt;

    logic               busy_d;
    logic               done_d;
    logic               rd_en_d;
    logic [LOG2N-1:0]   rd_addr_a_d;
    logic [LOG2N-1:0]   rd_addr_b_d;
    logic [TW_W-1:0]    tw_addr_d;

    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic [LOG2N-1:0]   rd_addr_a_q;
    logic [LOG2N-1:0]   rd_addr_b_q;
    logic [TW_W-1:0]    tw_addr_q;
    logic               wr_en_q;
    logic [LOG2N-1:0]   wr_addr_a_q;
    logic [LOG2N-1:0]   wr_addr_b_q;

    // Upper-leg address: butterfly index with a zero bit inserted at position s.
    function automatic logic [LOG2N-1:0] pair_base(input logic [LOG2N-1:0] s,
                                                   input logic [BF_W-1:0]  b);
        logic [LOG2N-1:0] bx;
        logic [LOG2N-1:0] low_mask;
        bx       = LOG2N'(b);
        low_mask = (LOG2N'(1) << s) - LOG2N'(1);
        return ((bx & ~low_mask) << 1) | (bx & low_mask);
    endfunction

    function automatic logic [TW_W-1:0] tw_index(input logic [LOG2N-1:0] s,
                                                 input logic [BF_W-1:0]  b);
        logic [LOG2N-1:0] k;
        k = LOG2N'(b) & ((LOG2N'(1) << s) - LOG2N'(1));
        return TW_W'(k << (TW_W - 32'(s)));
    endfunction

    // Write-back word, optionally halving each signed real/imag part (floor).
    function automatic logic [WORD_SZ-1:0] wr_word(input logic [WORD_SZ-1:0] w);
        logic signed [WORD_MID-1:0] re;
        logic signed [WORD_MID-1:0] im;
        re = w[WORD_SZ-1 -: WORD_MID];
        im = w[WORD_MID-1:0];
`ifdef FFT_STAGE_SCHED_SCALE_EN
        return WORD_SZ'({re >>> 1, im >>> 1});
`else
        return WORD_SZ'({re, im});
`endif
    endfunction

    // State register
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state <= S_IDLE;
            stage <= '0;
            bfly  <= '0;
        end else begin
            state <= state_nxt;
            stage <= stage_nxt;
            bfly  <= bfly_nxt;
        end
    end

    // Next-state: N/2 issue cycles, one bubble per stage, then a done cycle
    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        bfly_nxt  = bfly;
        unique case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_nxt = S_RUN;
                    stage_nxt = '0;
                    bfly_nxt  = '0;
                end
            end
            S_RUN: begin
                if (bfly == BF_W'(HALF_N - 1)) begin
                    state_nxt = S_DRAIN;
                    bfly_nxt  = '0;
                end else begin
                    bfly_nxt = bfly + BF_W'(1);
                end
            end
            S_DRAIN: begin
                if (stage == LOG2N'(LOG2N - 1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                    stage_nxt = stage + LOG2N'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                stage_nxt = '0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every control output is a flop
    always_comb begin
        busy_d      = 1'b0;
        done_d      = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_a_d = pair_base(stage_nxt, bfly_nxt);
        rd_addr_b_d = rd_addr_a_d + (LOG2N'(1) << stage_nxt);
        tw_addr_d   = tw_index(stage_nxt, bfly_nxt);
        unique case (state_nxt)
            S_RUN: begin
                busy_d  = 1'b1;
                rd_en_d = 1'b1;
            end
            S_DRAIN: busy_d = 1'b1;
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Issue registers, and the one-cycle delayed copy used as write-back address
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            if (rd_en_d) begin
                rd_addr_a_q <= rd_addr_a_d;
                rd_addr_b_q <= rd_addr_b_d;
                tw_addr_q   <= tw_addr_d;
            end
            wr_en_q     <= rd_en_q;
            wr_addr_a_q <= rd_addr_a_q;
            wr_addr_b_q <= rd_addr_b_q;
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_stage      = stage;
    assign bus.o_rd_en      = rd_en_q;
    assign bus.o_rd_addr_a  = rd_addr_a_q;
    assign bus.o_rd_addr_b  = rd_addr_b_q;
    assign bus.o_tw_addr    = tw_addr_q;

    // Read data reaches the butterfly and its results return to RAM in the same cycle
    assign bus.o_bf_A       = bus.i_rd_data_a;
    assign bus.o_bf_B       = bus.i_rd_data_b;
    assign bus.o_bf_twiddle = bus.i_tw_data;

    assign bus.o_wr_en      = wr_en_q;
    assign bus.o_wr_addr_a  = wr_addr_a_q;
    assign bus.o_wr_addr_b  = wr_addr_b_q;
    assign bus.o_wr_data_a  = wr_word(bus.i_bf_A);
    assign bus.o_wr_data_b  = wr_word(bus.i_bf_B);

endmodule

// File: doc/fft_stage_sched.md
Name: fft_stage_sched

Overview:
- Control and datapath sequencer for an in-place radix-2 DIT FFT over an N-point complex sample RAM.
- Generates read/write addresses and twiddle ROM indices, and drives operands into the combinational butterfly stage.
- Captures the butterfly's two results and writes them back in place.
- Sits directly upstream and downstream of the butterfly: it feeds A, B and twiddle, then consumes the outputs.
- Input data is assumed already in bit-reversed order.

Parameters:
- LOG2N, 4, log2 of FFT size N (N=16 default); N/2 butterflies per stage, LOG2N stages.
- WORD_SZ, 32, complex word width; {real[31:16], imag[15:0]}, two's complement.
- WORD_MID, 16, width of each real/imag half.

Ports:
- i_CLK  in  1  clock, all logic on rising edge.
- i_RST  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle request to run a full FFT; ignored unless IDLE.
- o_busy  out  1  high in RUN/DRAIN/DONE.
- o_done  out  1  one-cycle pulse when last write completes.
- o_stage  out  LOG2N  current stage index 0..LOG2N-1.
- o_rd_en  out  1  sample RAM and twiddle ROM read strobe.
- o_rd_addr_a  out  LOG2N  RAM read address, upper leg.
- o_rd_addr_b  out  LOG2N  RAM read address, lower leg.
- o_tw_addr  out  LOG2N-1  twiddle ROM address (N/2 entries).
- i_rd_data_a  in  WORD_SZ  RAM data for addr_a, valid 1 cycle after o_rd_en.
- i_rd_data_b  in  WORD_SZ  RAM data for addr_b, same timing.
- i_tw_data  in  WORD_SZ  ROM twiddle, same timing.
- o_bf_A  out  WORD_SZ  butterfly operand A.
- o_bf_B  out  WORD_SZ  butterfly operand B.
- o_bf_twiddle  out  WORD_SZ  butterfly twiddle.
- i_bf_A  in  WORD_SZ  butterfly sum output.
- i_bf_B  in  WORD_SZ  butterfly difference output.
- o_wr_en  out  1  RAM write strobe, both legs.
- o_wr_addr_a  out  LOG2N  write address, upper leg.
- o_wr_addr_b  out  LOG2N  write address, lower leg.
- o_wr_data_a  out  WORD_SZ  write data, upper leg.
- o_wr_data_b  out  WORD_SZ  write data, lower leg.

Clock is i_CLK; reset is i_RST, synchronous, active-high.

Behaviour:
- Reset: state IDLE; o_busy, o_done, o_rd_en, o_wr_en = 0; o_stage, counters, all address outputs = 0. Reset mid-run aborts at that edge; no write occurs in the following cycle. RAM contents are left partially transformed.
- FSM:
  - IDLE -> RUN on i_start.
  - RUN: issue one butterfly per cycle, b = 0..N/2-1. After b = N/2-1 -> DRAIN.
  - DRAIN: one bubble cycle; the last write lands here. Avoids read-during-write across stages. DRAIN -> RUN with stage+1, b=0; from the last stage -> DONE.
  - DONE: o_done=1 for one cycle -> IDLE.
- Addressing (stage s, half=1<<s):
  - k = b & (half-1); j = b >> s.
  - addr_a = (j << (s+1)) | k; addr_b = addr_a + half.
  - tw_addr = k << (LOG2N-1-s).
- Pipeline stage 1 (issue), cycle t: o_rd_en=1 with addresses. Addresses are registered and delayed 1 cycle as write addresses.
- Pipeline stage 2 (compute/write), cycle t+1:
  - o_bf_A/B/twiddle = i_rd_data_a/b and i_tw_data, combinational pass-through.
  - o_wr_en=1; o_wr_data = i_bf_A/i_bf_B (combinational), to delayed addresses.
- Throughput: 1 butterfly/cycle; o_rd_en is never high in DRAIN or DONE.
- Total latency: the start-accept edge is followed by LOG2N*(N/2+1) RUN/DRAIN cycles, then o_done. N=16: o_done in cycle 37 after accept.
- i_start while busy: ignored, no restart. i_start in the same cycle as o_done: ignored.
- Arithmetic: the block performs none except the optional scaling; widths are preserved; no saturation.

Optional Feature:
- Macro FFT_STAGE_SCHED_SCALE_EN.
- Defined: o_wr_data_a/b = each 16-bit half of i_bf_A/i_bf_B arithmetic-shifted right by 1 (sign preserved, truncate toward -inf). Gives a total 1/N scaling and prevents overflow.
- Undefined: write data equals butterfly outputs unmodified.

Test Plan:
- N=16, pulse i_start -> stage 0 read pairs (0,1),(2,3)..(14,15), tw 0; stage 3 pairs (0,8),(1,9)..(7,15), tw 0..7; writes 1 cycle after reads to the same pairs.
- Timing: o_rd_en low in each DRAIN cycle; o_done pulses exactly cycle 37 after accept; o_busy low the next cycle.
- Impulse: RAM x[0]=0x4000_0000, rest 0, with real butterfly and ROM models -> unscaled, all 16 bins 0x4000_0000. With FFT_STAGE_SCHED_SCALE_EN -> all bins 0x0400_0000.
- i_start reasserted at cycle 10 of a run -> no restart; o_done still at cycle 37; single pulse.
- i_RST high in a RUN cycle with a pending write -> next cycle o_wr_en=0, o_busy=0, o_stage=0. A fresh i_start then completes normally.
- DC input, all x=0x1000_0000, scaled build -> bin 0 = 0x1000_0000, bins 1..15 = 0.
